sync_fifo_flex: RTL and testbench

SYNC_FIFO_FLEX -- requirements
Module: sync_fifo_flex

---
 rtl/sync_fifo_flex.sv | 109 ++++++++++
 tb/tb_sync_fifo_flex.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with registered level/status flags, sticky error flags
// and a selectable read style (registered read or first-word-fall-through).
module sync_fifo_flex #(
  parameter int DSIZE             = 8,
  parameter int ASIZE             = 3,
  parameter int ALMOST_FULL_SIZE  = 5,
  parameter int ALMOST_EMPTY_SIZE = 3,
  parameter int FWFT              = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             w_almost_full,
  output logic [DSIZE-1:0] rdata,
  input  logic             rinc,
  output logic             rempty,
  output logic             r_almost_empty,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_L = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_L    = (ASIZE+1)'(ALMOST_FULL_SIZE);
  localparam logic [ASIZE:0] AE_L    = (ASIZE+1)'(ALMOST_EMPTY_SIZE);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE-1:0] wptr, rptr;
  logic [ASIZE:0]   level_nxt;
  logic [DSIZE-1:0] rdata_q;
  logic             wr_acc, rd_acc;

  // Acceptance uses the registered flags, so a full FIFO can still take a
  // read in the same cycle it refuses a write (and vice versa when empty).
  assign wr_acc = winc & ~wfull;
  assign rd_acc = rinc & ~rempty;

  // Next stored-word count; both or neither accepted leaves it unchanged.
  always_comb begin
    level_nxt = level;
    case ({wr_acc, rd_acc})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH since they are exactly ASIZE bits wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
    end
  end

  // Level and status flags registered together from the next level so they
  // always agree with each other in any given cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level          <= '0;
      wfull          <= 1'b0;
      w_almost_full  <= 1'b0;
      rempty         <= 1'b1;
      r_almost_empty <= 1'b1;
    end else begin
      level          <= level_nxt;
      wfull          <= (level_nxt == DEPTH_L);
      w_almost_full  <= (level_nxt >= AF_L);
      rempty         <= (level_nxt == '0);
      r_almost_empty <= (level_nxt <= AE_L);
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc & wfull)  overflow <= 1'b1;
      else if (err_clr)  overflow <= 1'b0;
      if (rinc & rempty) underflow <= 1'b1;
      else if (err_clr)  underflow <= 1'b0;
    end
  end

  // Registered read port: loads the head word on the edge that accepts a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rdata_q <= '0;
    else if (rd_acc) rdata_q <= mem[rptr];
  end

  // In fall-through mode the head word is presented directly; its value is
  // meaningless while rempty is high.
  assign rdata = (FWFT != 0) ? mem[rptr] : rdata_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Scoreboard bench: one registered-read and one fall-through FIFO share the
// same stimulus; expected words are queued on accepted writes and popped on
// accepted reads.
module tb_sync_fifo_flex;

  logic       clk = 1'b0;
  logic       rst, winc, rinc, err_clr;
  logic [7:0] wdata;

  logic       wfull0, afull0, rempty0, aempty0, ovf0, udf0;
  logic [7:0] rdata0;
  logic [3:0] level0;
  logic       wfull1, afull1, rempty1, aempty1, ovf1, udf1;
  logic [7:0] rdata1;
  logic [3:0] level1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] q[$];
  int         mlevel;
  logic       movf, mudf;

  always #5 clk = ~clk;

  sync_fifo_flex #(.FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .wfull(wfull0),
    .w_almost_full(afull0), .rdata(rdata0), .rinc(rinc), .rempty(rempty0),
    .r_almost_empty(aempty0), .level(level0), .overflow(ovf0),
    .underflow(udf0), .err_clr(err_clr));

  sync_fifo_flex #(.FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .wfull(wfull1),
    .w_almost_full(afull1), .rdata(rdata1), .rinc(rinc), .rempty(rempty1),
    .r_almost_empty(aempty1), .level(level1), .overflow(ovf1),
    .underflow(udf1), .err_clr(err_clr));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Status of both DUTs against the model level and sticky flags.
  task automatic chk_status(input string tag);
    chk({tag, " level"},  32'(level0), 32'(mlevel));
    chk({tag, " wfull"},  32'(wfull0), 32'(mlevel == 8));
    chk({tag, " afull"},  32'(afull0), 32'(mlevel >= 5));
    chk({tag, " rempty"}, 32'(rempty0), 32'(mlevel == 0));
    chk({tag, " aempty"}, 32'(aempty0), 32'(mlevel <= 3));
    chk({tag, " ovf"},    32'(ovf0), 32'(movf));
    chk({tag, " udf"},    32'(udf0), 32'(mudf));
    chk({tag, " level1"}, 32'(level1), 32'(mlevel));
    chk({tag, " rempty1"},32'(rempty1), 32'(mlevel == 0));
    chk({tag, " ovf1"},   32'(ovf1), 32'(movf));
    chk({tag, " udf1"},   32'(udf1), 32'(mudf));
  endtask

  // One clock of stimulus; called shortly after a rising edge.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r,
                       input logic clr, input string tag);
    logic       wacc, racc;
    logic [7:0] head;
    head    = 8'h00;
    winc    = w;
    wdata   = d;
    rinc    = r;
    err_clr = clr;
    wacc = w && (mlevel != 8);
    racc = r && (mlevel != 0);
    if (racc) begin
      head = q.pop_front();
      chk({tag, " fwft head"}, 32'(rdata1), 32'(head));
    end
    if (wacc) q.push_back(d);
    if (w && mlevel == 8)      movf = 1'b1;
    else if (clr)              movf = 1'b0;
    if (r && mlevel == 0)      mudf = 1'b1;
    else if (clr)              mudf = 1'b0;
    if (wacc && !racc) mlevel++;
    if (racc && !wacc) mlevel--;
    @(posedge clk);
    #1;
    winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
    chk_status(tag);
    if (racc) chk({tag, " rdata"}, 32'(rdata0), 32'(head));
    if (mlevel != 0) chk({tag, " fwft rdata"}, 32'(rdata1), 32'(q[0]));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " level"},  32'(level0), 32'd0);
    chk({tag, " rempty"}, 32'(rempty0), 32'd1);
    chk({tag, " aempty"}, 32'(aempty0), 32'd1);
    chk({tag, " wfull"},  32'(wfull0), 32'd0);
    chk({tag, " afull"},  32'(afull0), 32'd0);
    chk({tag, " ovf"},    32'(ovf0), 32'd0);
    chk({tag, " udf"},    32'(udf0), 32'd0);
    chk({tag, " rdata"},  32'(rdata0), 32'd0);
    chk({tag, " level1"}, 32'(level1), 32'd0);
    chk({tag, " rempty1"},32'(rempty1), 32'd1);
  endtask

  initial begin
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0; wdata = 8'h00;
    mlevel = 0; movf = 1'b0; mudf = 1'b0;
    #12;
    chk_reset("reset");
    rst = 1'b0;

    // Fill with 0x10..0x17, then one write too many.
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "fill");
    // Drain in order, then one read too many.
    for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr both");

    // Fall-through visibility of a single word.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, "fwft wr");
    chk("fwft a5", 32'(rdata1), 32'h0000_00A5);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "fwft rd");

    // Simultaneous read/write at full, then at empty.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, "fill2");
    cycle(1'b1, 8'hEE, 1'b1, 1'b0, "full rw");
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
    cycle(1'b1, 8'h5A, 1'b1, 1'b0, "empty rw");
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr2");

    // Mid-level simultaneous traffic and random mix.
    cycle(1'b1, 8'h61, 1'b0, 1'b0, "mid w");
    cycle(1'b1, 8'h62, 1'b1, 1'b0, "mid rw");
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'b0, "rand");
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr3");

    // Drain, build to level 4, reset away from any edge.
    while (mlevel > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0, "pre rst");
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, "lvl4");
    #2 rst = 1'b1;
    #1 chk_reset("mid rst");
    q.delete(); mlevel = 0; movf = 1'b0; mudf = 1'b0;
    #2 rst = 1'b0;

    // First edge after reset accepts a write.
    cycle(1'b1, 8'h81, 1'b0, 1'b0, "post rst");

    // err_clr loses to a same-cycle error, clears on its own.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, "fill3");
    cycle(1'b1, 8'hFF, 1'b0, 1'b1, "clr vs ovf");
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr ovf");
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain3");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
